// File: rtl/irq_controller_pkg.sv
// Shared CLINT register offsets, mip bit positions and mcause interrupt codes.
// Also consumed by the CSR file and the exception unit.
package irq_controller_pkg;

  localparam logic [15:0] OFF_MSIP        = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

  localparam int MSIP_BIT = 3;
  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;

  typedef enum logic [3:0] {
    CAUSE_NONE = 4'd0,
    CAUSE_MSI  = 4'd3,
    CAUSE_MTI  = 4'd7,
    CAUSE_MEI  = 4'd11
  } irq_cause_e;

  // Fixed priority: external > software > timer.
  function automatic irq_cause_e pick_cause(input logic mei, input logic msi, input logic mti);
    if (mei)      return CAUSE_MEI;
    else if (msi) return CAUSE_MSI;
    else if (mti) return CAUSE_MTI;
    else          return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// MEM-stage load/store port into the CLINT register window.
interface irq_controller_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        bus_hit;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    input  bus_rdata, bus_hit
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    output bus_rdata, bus_hit
  );
endinterface

// File: rtl/irq_controller_sync2.sv
// Two-flop synchroniser for the asynchronous external interrupt line.
module irq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/irq_controller.sv
// Machine-level interrupt source: msip, 64-bit mtime/mtimecmp, synchronised external IRQ,
// gated into a single irq_req/irq_cause for the exception unit.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          PRESCALE  = 1,
  parameter int          HOLDOFF   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_irq,
  input  logic             mstatus_mie,
  input  logic [31:0]      mie,
  input  logic             irq_inhibit,
  input  logic             irq_ack,
  output logic             irq_req,
  output logic [3:0]       irq_cause,
  output logic [31:0]      mip,
  irq_controller_if.slave  bus
);

  localparam int PW = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic          msip;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic [PW-1:0] pre;
  logic [HW-1:0] holdoff;
  logic          meip;
  logic          mtip;
  logic          tick;
  logic          hit;
  logic [15:0]   offset;
  logic          wr;
  logic [31:0]   en;

  irq_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_irq),
    .q   (meip)
  );

  assign offset = bus.bus_addr[15:0];
  assign hit    = (bus.bus_addr[31:16] == BASE_ADDR[31:16]);
  assign wr     = bus.bus_we & hit;
  assign tick   = (pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      msip     <= 1'b0;
      mtime    <= '0;
      mtimecmp <= '1;
      pre      <= '0;
      holdoff  <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;

      if (wr && offset == OFF_MSIP)        msip            <= bus.bus_wdata[0];
      if (wr && offset == OFF_MTIMECMP_LO) mtimecmp[31:0]  <= bus.bus_wdata;
      if (wr && offset == OFF_MTIMECMP_HI) mtimecmp[63:32] <= bus.bus_wdata;

      // A store to either half of mtime swallows a coincident tick.
      if (wr && offset == OFF_MTIME_LO)      mtime[31:0]  <= bus.bus_wdata;
      else if (wr && offset == OFF_MTIME_HI) mtime[63:32] <= bus.bus_wdata;
      else if (tick)                         mtime        <= mtime + 64'd1;

      // Only an acknowledged live request arms the holdoff window.
      if (irq_ack && irq_req)    holdoff <= HW'(HOLDOFF);
      else if (holdoff != '0)    holdoff <= holdoff - 1'b1;
    end
  end

  assign mtip = (mtime >= mtimecmp);

  always_comb begin
    mip           = '0;
    mip[MEIP_BIT] = meip;
    mip[MTIP_BIT] = mtip;
    mip[MSIP_BIT] = msip;
  end

  assign en        = mip & mie;
  assign irq_cause = pick_cause(en[MEIP_BIT], en[MSIP_BIT], en[MTIP_BIT]);
  assign irq_req   = mstatus_mie & (|en) & ~irq_inhibit & (holdoff == '0);

  always_comb begin
    bus.bus_rdata = '0;
    if (bus.bus_re && hit) begin
      case (offset)
        OFF_MSIP:        bus.bus_rdata = {31'b0, msip};
        OFF_MTIMECMP_LO: bus.bus_rdata = mtimecmp[31:0];
        OFF_MTIMECMP_HI: bus.bus_rdata = mtimecmp[63:32];
        OFF_MTIME_LO:    bus.bus_rdata = mtime[31:0];
        OFF_MTIME_HI:    bus.bus_rdata = mtime[63:32];
        default:         bus.bus_rdata = '0;
      endcase
    end
  end

  assign bus.bus_hit = hit;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed sequences, a vector table and a randomized run
// against a behavioural model.
module tb_irq_controller;
  import irq_controller_pkg::*;

  localparam logic [31:0] A = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq, mstatus_mie, irq_inhibit, irq_ack;
  logic [31:0] mie;
  logic        irq_req, req3;
  logic [3:0]  irq_cause, cause3;
  logic [31:0] mip, mip3;

  always #5 clk = ~clk;

  irq_controller_if bus ();
  irq_controller_if bus3 ();

  irq_controller #(.BASE_ADDR(A), .PRESCALE(1), .HOLDOFF(3)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie), .mie(mie),
    .irq_inhibit(irq_inhibit), .irq_ack(irq_ack), .irq_req(irq_req), .irq_cause(irq_cause),
    .mip(mip), .bus(bus)
  );

  irq_controller #(.BASE_ADDR(A), .PRESCALE(3), .HOLDOFF(3)) dut3 (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie), .mie(mie),
    .irq_inhibit(irq_inhibit), .irq_ack(irq_ack), .irq_req(req3), .irq_cause(cause3),
    .mip(mip3), .bus(bus3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic store(input logic [15:0] off, input logic [31:0] d);
    bus.bus_addr  = A | {16'h0, off};
    bus.bus_wdata = d;
    bus.bus_we    = 1'b1;
    cyc();
    bus.bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] off, output logic [31:0] d);
    bus.bus_addr = A | {16'h0, off};
    bus.bus_re   = 1'b1;
    #1;
    d = bus.bus_rdata;
  endtask

  // Behavioural reference: register contents as plain values, sync as a sample history.
  logic        m_msip;
  logic [63:0] m_mtime, m_cmp;
  logic [1:0]  m_ext_hist;
  int          m_hold;

  task automatic model_reset();
    m_msip = 1'b0; m_mtime = 64'd0; m_cmp = '1; m_ext_hist = 2'b00; m_hold = 0;
  endtask

  function automatic logic [31:0] model_mip();
    logic [31:0] v;
    v = 32'h0;
    if (m_ext_hist[1])     v = v | 32'h800;
    if (m_mtime >= m_cmp)  v = v | 32'h080;
    if (m_msip)            v = v | 32'h008;
    return v;
  endfunction

  function automatic logic [3:0] model_cause(input logic [31:0] mie_v);
    logic [31:0] e;
    e = model_mip() & mie_v;
    if (e[11]) return 4'd11;
    if (e[3])  return 4'd3;
    if (e[7])  return 4'd7;
    return 4'd0;
  endfunction

  function automatic logic model_req(input logic mm, input logic [31:0] mie_v, input logic inh);
    return mm && ((model_mip() & mie_v) != 0) && !inh && (m_hold == 0);
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] addr, input logic re);
    if (!re || addr[31:16] != 16'h0200) return 32'h0;
    case (addr[15:0])
      16'h0000: return {31'b0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[31:0];
      16'hBFFC: return m_mtime[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic e, input logic ack, input logic req_now,
                            input logic we, input logic [31:0] addr, input logic [31:0] d);
    logic st;
    if (!r) begin
      model_reset();
      return;
    end
    st = we && addr[31:16] == 16'h0200;
    if (st && addr[15:0] == 16'h0000) m_msip = d[0];
    if (st && addr[15:0] == 16'h4000) m_cmp = {m_cmp[63:32], d};
    if (st && addr[15:0] == 16'h4004) m_cmp = {d, m_cmp[31:0]};
    if (st && addr[15:0] == 16'hBFF8)      m_mtime = {m_mtime[63:32], d};
    else if (st && addr[15:0] == 16'hBFFC) m_mtime = {d, m_mtime[31:0]};
    else                                   m_mtime = m_mtime + 64'd1;
    if (ack && req_now)  m_hold = 3;
    else if (m_hold > 0) m_hold = m_hold - 1;
    m_ext_hist = {m_ext_hist[0], e};
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] mie;
    logic        mmie;
    logic        inh;
    logic [31:0] rdata;
    logic        hit;
    logic        req;
    logic [3:0]  cause;
    logic [31:0] mip;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] d;
    int cnt;

    // Starting state: msip=0, mtimecmp=0x1_0000_000A, mtime small, ext low, no holdoff.
    tbl[0] = '{A | 32'h0000,  1'b1, 32'h1,         32'h8,   1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0};
    tbl[1] = '{A | 32'h0000,  1'b0, 32'h0,         32'h8,   1'b0, 1'b0, 32'h1, 1'b1, 1'b0, 4'd3, 32'h8};
    tbl[2] = '{A | 32'h0004,  1'b1, 32'hFFFF_FFFF, 32'h8,   1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 4'd3, 32'h8};
    tbl[3] = '{32'h0300_0000, 1'b1, 32'h0,         32'h8,   1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'd3, 32'h8};
    tbl[4] = '{A | 32'h0000,  1'b0, 32'h0,         32'h0,   1'b1, 1'b0, 32'h1, 1'b1, 1'b0, 4'd0, 32'h8};
    tbl[5] = '{A | 32'h4000,  1'b0, 32'h0,         32'h8,   1'b1, 1'b0, 32'hA, 1'b1, 1'b1, 4'd3, 32'h8};
    tbl[6] = '{A | 32'h0000,  1'b1, 32'hFFFF_FFFE, 32'h8,   1'b1, 1'b0, 32'h1, 1'b1, 1'b1, 4'd3, 32'h8};
    tbl[7] = '{A | 32'h0000,  1'b0, 32'h0,         32'h8,   1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0};
    tbl[8] = '{A | 32'h4004,  1'b0, 32'h0,         32'h888, 1'b1, 1'b0, 32'h1, 1'b1, 1'b0, 4'd0, 32'h0};

    rst = 1'b0; ext_irq = 1'b1; mstatus_mie = 1'b0; mie = 32'h0; irq_inhibit = 1'b0; irq_ack = 1'b0;
    bus.bus_addr = A; bus.bus_wdata = 32'h0; bus.bus_we = 1'b0; bus.bus_re = 1'b1;
    bus3.bus_addr = A | 32'hBFF8; bus3.bus_wdata = 32'h0; bus3.bus_we = 1'b0; bus3.bus_re = 1'b1;

    // Reset held with ext_irq high.
    repeat (4) cyc();
    #1;
    chk("rst_req", irq_req, 0);
    chk("rst_mip", mip, 0);
    chk("rst_cause", irq_cause, 0);
    rd(16'hBFF8, d); chk("rst_mtime_lo", d, 32'h0);
    rd(16'h4000, d); chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
    rd(16'h4004, d); chk("rst_cmp_hi", d, 32'hFFFF_FFFF);

    ext_irq = 1'b0; rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      rd(16'hBFF8, d); chk("mtime_count", d, k);
      #1; chk("mtime_prescale3", bus3.bus_rdata, k / 3);
    end

    // Timer compare.
    mie = 32'h80; mstatus_mie = 1'b1;
    store(16'h4004, 32'h0);
    store(16'h4000, 32'd10);
    store(16'hBFF8, 32'h0);
    bus.bus_addr = A | 32'hBFF8;
    #1;
    cnt = 0;
    while (!irq_req && cnt < 40) begin
      cyc(); #1; cnt++;
    end
    chk("timer_cycles", cnt, 10);
    chk("timer_mtime", bus.bus_rdata, 32'd10);
    chk("timer_cause", irq_cause, 7);
    chk("timer_mip", mip, 32'h80);
    bus.bus_addr = A | 32'h4004; bus.bus_wdata = 32'h1; bus.bus_we = 1'b1;
    #1; chk("timer_req_before_hi", irq_req, 1);
    cyc(); bus.bus_we = 1'b0;
    #1; chk("timer_req_after_hi", irq_req, 0);

    // Priority.
    mie = 32'h888;
    store(16'h0000, 32'h1);
    store(16'h4004, 32'h0);
    #1; chk("prio_msi_over_mti", irq_cause, 3);
    chk("prio_mip", mip, 32'h88);
    ext_irq = 1'b1;
    cyc(); #1; chk("prio_sync_not_yet", irq_cause, 3);
    cyc(); cyc(); #1; chk("prio_mei", irq_cause, 11);
    chk("prio_mip_all", mip, 32'h888);
    ext_irq = 1'b0;
    repeat (3) cyc();
    #1; chk("prio_ext_drop", irq_cause, 3);
    store(16'h0000, 32'h0);
    #1; chk("prio_msip_clear", irq_cause, 7);
    chk("prio_mip_mti", mip, 32'h80);

    // Handshake and holdoff.
    irq_ack = 1'b1;
    #1; chk("hs_req_at_ack", irq_req, 1);
    cyc(); irq_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("hs_holdoff_low", irq_req, 0);
      cyc();
    end
    #1; chk("hs_req_back", irq_req, 1);
    mstatus_mie = 1'b0; irq_ack = 1'b1;
    #1; chk("hs_masked_req", irq_req, 0);
    cyc(); irq_ack = 1'b0; mstatus_mie = 1'b1;
    #1; chk("hs_ack_ignored", irq_req, 1);
    bus.bus_addr = A | 32'h4004; bus.bus_wdata = 32'h1; bus.bus_we = 1'b1; irq_ack = 1'b1;
    #1; chk("hs_sim_cause", irq_cause, 7);
    cyc(); bus.bus_we = 1'b0; irq_ack = 1'b0;
    repeat (4) cyc();
    #1; chk("hs_sim_req", irq_req, 0);
    chk("hs_sim_mip", mip, 0);

    // Masking and decode table.
    foreach (tbl[i]) begin
      bus.bus_addr = tbl[i].addr; bus.bus_we = tbl[i].we; bus.bus_wdata = tbl[i].wdata;
      bus.bus_re = 1'b1; mie = tbl[i].mie; mstatus_mie = tbl[i].mmie; irq_inhibit = tbl[i].inh;
      #1;
      chk($sformatf("tbl%0d_rdata", i), bus.bus_rdata, tbl[i].rdata);
      chk($sformatf("tbl%0d_hit", i), bus.bus_hit, tbl[i].hit);
      chk($sformatf("tbl%0d_req", i), irq_req, tbl[i].req);
      chk($sformatf("tbl%0d_cause", i), irq_cause, tbl[i].cause);
      chk($sformatf("tbl%0d_mip", i), mip, tbl[i].mip);
      cyc();
    end
    bus.bus_we = 1'b0; irq_inhibit = 1'b0;

    // 64-bit wrap and store-vs-tick.
    mie = 32'h0;
    store(16'hBFFC, 32'hFFFF_FFFF);
    store(16'hBFF8, 32'hFFFF_FFFE);
    rd(16'hBFF8, d); chk("wrap_fe", d, 32'hFFFF_FFFE);
    chk("wrap_mtip", mip, 32'h80);
    cyc(); rd(16'hBFF8, d); chk("wrap_ff", d, 32'hFFFF_FFFF);
    cyc(); rd(16'hBFF8, d); chk("wrap_lo0", d, 32'h0);
    rd(16'hBFFC, d); chk("wrap_hi0", d, 32'h0);
    chk("wrap_mip", mip, 0);
    store(16'hBFFC, 32'h1234);
    store(16'hBFF8, 32'h5);
    rd(16'hBFF8, d); chk("tick_lost_lo", d, 32'h5);
    rd(16'hBFFC, d); chk("tick_lost_hi", d, 32'h1234);
    cyc(); rd(16'hBFF8, d); chk("tick_resume", d, 32'h6);

    // Randomized run against the reference model.
    rst = 1'b0; ext_irq = 1'b0; irq_ack = 1'b0;
    cyc();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] off;
      logic [31:0] base, wd;
      logic        e_req;
      rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0) ext_irq = ~ext_irq;
      mstatus_mie = ($urandom_range(0, 7) != 0);
      mie = ($urandom & 32'h888) | ($urandom & 32'hFFFF_F777);
      irq_inhibit = ($urandom_range(0, 7) == 0);
      irq_ack = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 6))
        0: off = 16'h0000;
        1: off = 16'h4000;
        2: off = 16'h4004;
        3: off = 16'hBFF8;
        4: off = 16'hBFFC;
        5: off = 16'($urandom);
        default: off = 16'($urandom_range(0, 15) << 2);
      endcase
      base = ($urandom_range(0, 9) == 0) ? 32'h0201_0000 : A;
      if (off == 16'h4004 || off == 16'hBFFC) wd = ($urandom_range(0, 9) == 0) ? 32'h1 : 32'h0;
      else if (off == 16'h4000 || off == 16'hBFF8) wd = $urandom_range(0, 3000);
      else wd = $urandom;
      bus.bus_addr = base | {16'h0, off}; bus.bus_wdata = wd;
      bus.bus_we = ($urandom_range(0, 3) == 0); bus.bus_re = $urandom_range(0, 1);
      #1;
      e_req = model_req(mstatus_mie, mie, irq_inhibit);
      chk("rnd_req", irq_req, e_req);
      chk("rnd_cause", irq_cause, model_cause(mie));
      chk("rnd_mip", mip, model_mip());
      chk("rnd_rdata", bus.bus_rdata, model_rdata(bus.bus_addr, bus.bus_re));
      chk("rnd_hit", bus.bus_hit, bus.bus_addr[31:16] == 16'h0200);
      model_step(rst, ext_irq, irq_ack, e_req, bus.bus_we, bus.bus_addr, wd);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
